// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI slave transmit path.
package spi_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } spi_state_t;

endpackage

// File: rtl/sync_fifo_byte.sv
// Single-clock byte FIFO with a separate occupancy counter and
// combinational head-of-queue read data.
module sync_fifo_byte
    import spi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [BYTE_W-1:0]            i_wr_data,
    input  logic                         i_rd_en,
    output logic [BYTE_W-1:0]            o_rd_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic              w_push;
    logic              w_pop;

    assign o_full    = (r_level == FULL_LVL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_mem[r_rptr];

    // Guard locally so a careless caller can never corrupt the pointers.
    assign w_push = i_wr_en && !o_full;
    assign w_pop  = i_rd_en && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spi_tx_fifo.sv
// Transmit byte buffer and frame sequencer feeding the SPI slave:
// header byte (buffered count), then FIFO data, filler on underrun.
module spi_tx_fifo
    import spi_pkg::*;
#(
    parameter int                DEPTH     = 16,
    parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [BYTE_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         frame_start,
    input  logic                         frame_end,
    input  logic                         tx_req,
    output logic [BYTE_W-1:0]            tx_byte,
    output logic                         tx_byte_valid,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [7:0]                   underrun_cnt
);

    localparam int LVL_W = $clog2(DEPTH+1);

    spi_state_t        r_state;
    spi_state_t        w_state_nxt;
    logic [BYTE_W-1:0] r_hdr;
    logic [BYTE_W-1:0] r_tx_byte;
    logic              r_tx_vld;
    logic [7:0]        r_urun;

    logic [BYTE_W-1:0] w_byte_nxt;
    logic              w_vld_nxt;
    logic              w_pop;
    logic              w_urun_inc;
    logic              w_hdr_load;
    logic [BYTE_W-1:0] w_hdr_now;
    logic [BYTE_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [LVL_W-1:0]  w_level;

    function automatic logic [BYTE_W-1:0] sat_hdr(input logic [LVL_W-1:0] lvl);
        logic [31:0] v;
        v = 32'(lvl);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

    sync_fifo_byte #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (in_valid && !w_full),
        .i_wr_data (in_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    assign in_ready      = !w_full;
    assign level         = w_level;
    assign tx_byte       = r_tx_byte;
    assign tx_byte_valid = r_tx_vld;
    assign underrun_cnt  = r_urun;
    assign w_hdr_now     = sat_hdr(w_level);

    // frame_end dominates everything, then frame_start, then the state itself.
    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = IDLE_BYTE;
        w_vld_nxt   = 1'b0;
        w_pop       = 1'b0;
        w_urun_inc  = 1'b0;
        w_hdr_load  = 1'b0;
        if (frame_end) begin
            w_state_nxt = IDLE;
        end else if (frame_start) begin
            w_hdr_load = 1'b1;
            if (tx_req) begin
                w_byte_nxt  = w_hdr_now;
                w_vld_nxt   = 1'b1;
                w_state_nxt = DATA;
            end else begin
                w_state_nxt = HDR;
            end
        end else begin
            case (r_state)
                HDR: begin
                    if (tx_req) begin
                        w_byte_nxt  = r_hdr;
                        w_vld_nxt   = 1'b1;
                        w_state_nxt = DATA;
                    end
                end
                DATA: begin
                    if (tx_req) begin
                        if (!w_empty) begin
                            w_byte_nxt = w_head;
                            w_vld_nxt  = 1'b1;
                            w_pop      = 1'b1;
                        end else begin
                            w_urun_inc = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr     <= '0;
            r_tx_byte <= IDLE_BYTE;
            r_tx_vld  <= 1'b0;
            r_urun    <= '0;
        end else begin
            if (w_hdr_load) begin
                r_hdr <= w_hdr_now;
            end
            if (tx_req) begin
                r_tx_byte <= w_byte_nxt;
                r_tx_vld  <= w_vld_nxt;
            end
            if (w_urun_inc && (r_urun != 8'hFF)) begin
                r_urun <= r_urun + 8'd1;
            end
        end
    end

endmodule

// File: doc/spi_tx_fifo.md
Name: spi_tx_fifo

Overview:
Byte buffer and frame sequencer directly upstream of the SPI slave transmitter. Producer logic (sensor/vision) pushes bytes over valid/ready. The SPI slave requests one byte per 8-bit slot and frames transactions with synchronised SS edge pulses. Each frame begins with a header byte giving the number of bytes buffered, then drains the FIFO; empty slots are padded with a filler byte and counted as underruns.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
IDLE_BYTE, 8'h00, byte returned when no data is available or outside a frame

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
in_data  input  8  producer byte
in_valid  input  1  producer byte valid
in_ready  output  1  FIFO can accept; equals not-full
frame_start  input  1  one-cycle pulse, SS falling edge (already synchronised by the slave)
frame_end  input  1  one-cycle pulse, SS rising edge
tx_req  input  1  one-cycle pulse, slave needs the next byte
tx_byte  output  8  byte for the slave shift register; registered
tx_byte_valid  output  1  1 if tx_byte is header or FIFO data, 0 if filler
level  output  $clog2(DEPTH+1)  current FIFO occupancy
underrun_cnt  output  8  saturating count of filler bytes served inside frames

Behaviour:
- Reset (async, rst_n=0): FIFO empty, pointers 0, level=0, state IDLE, tx_byte=IDLE_BYTE, tx_byte_valid=0, underrun_cnt=0. in_ready=1 once not full.
- Push: happens when in_valid && in_ready. in_ready is combinational !full and does not depend on a same-cycle pop, so there is no push-through when full.
- Pop: happens only on tx_req in state DATA with level>0.
- Empty FIFO: no bypass. A same-cycle push and tx_req returns filler, and the pushed byte is stored.
- Pointers: log2(DEPTH) bits, wrap naturally. level is a separate counter: +1 on push only, -1 on pop only, unchanged when both occur.
- States:
  - IDLE: tx_req -> tx_byte=IDLE_BYTE, valid=0, no underrun count. frame_start -> HDR.
  - HDR: entered on frame_start; hdr_reg <= min(level,255) sampled on the frame_start cycle. tx_req -> tx_byte=hdr_reg, valid=1, -> DATA.
  - DATA: tx_req with level>0 -> tx_byte=head entry, valid=1, pop. tx_req with level==0 -> tx_byte=IDLE_BYTE, valid=0, underrun_cnt+1 (saturates at 255).
- From any state: frame_end -> IDLE.
- frame_start in HDR or DATA: restarts the frame (new header sample, -> HDR).
- Simultaneous frame_start and frame_end: frame_end wins, -> IDLE, header not sampled.
- Same-cycle frame_start and tx_req: tx_req is served as HDR. The header equals the level on that cycle, and the state goes to DATA.
- Same-cycle frame_end and tx_req: tx_req is served as IDLE (filler, no count).
- Latency: tx_byte/tx_byte_valid update on the clock edge that samples tx_req (visible the cycle after the pulse) and hold until the next tx_req.
- Occupancy: the header is informational only. Bytes pushed after the header is sampled are still sent in the same frame.
- Bytes not drained by frame end stay in the FIFO for the next frame.
- underrun_cnt is cleared only by reset.
- Reset mid-frame: immediate return to reset values; buffered data is discarded.

Decomposition:
- Shared package spi_pkg:
  - IDLE_BYTE default constant.
  - State enum {IDLE, HDR, DATA}.
  - Byte width constant 8, shared with spi_slave.
- One natural sub-module: sync_fifo_byte (storage array, pointers, level, full/empty), instantiated once. spi_tx_fifo holds the FSM, header register and underrun counter.

Test Plan:
- Reset, push 0x11,0x22,0x33; frame_start; 4 tx_req -> tx_byte 0x03,0x11,0x22,0x33, valid=1 each; level ends 0.
- Frame on empty FIFO: frame_start, 3 tx_req -> 0x00(valid=1 header),0x00(valid=0),0x00(valid=0); underrun_cnt=2. Then frame_end, 1 tx_req -> filler, underrun_cnt stays 2.
- Fill with DEPTH=16 bytes 0x00..0x0F -> in_ready=0, level=16. A 17th in_valid is not accepted. One pop in DATA -> in_ready=1 the next cycle.
- Same-cycle push and tx_req with FIFO empty in DATA -> filler served, valid=0, level=1. Next tx_req returns the pushed byte.
- frame_start and frame_end in the same cycle -> state IDLE, next tx_req gives IDLE_BYTE, valid=0. Assert rst_n low mid-DATA -> outputs return to reset values without a clock edge.
- Pointer wrap: push/pop 40 bytes through a 16-deep FIFO in 3 frames -> output sequence identical to input order, no loss or duplication.
